// File: rtl/fx3_pkg.sv
// Shared defaults and types for the FX3 stream-in path.
package fx3_pkg;
  localparam int DATA_W      = 32;
  localparam int BURST_WORDS = 4092;
  localparam int FIFO_DEPTH  = 8192;

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, BURST = 2'd2} fx3_si_state_t;
  typedef logic [DATA_W-1:0] fx3_word_t;
endpackage

// File: rtl/fx3_sync_fifo.sv
// Single-clock FIFO with registered read data; storage has no reset so it maps to block RAM.
// The caller qualifies push/pop against full/empty.
module fx3_sync_fifo
  import fx3_pkg::*;
#(
  parameter int DATA_W = fx3_pkg::DATA_W,
  parameter int DEPTH  = fx3_pkg::FIFO_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic                      push,
  input  logic                      pop,
  input  logic [DATA_W-1:0]         din,
  output logic [DATA_W-1:0]         dout,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;

  // Extra MSB distinguishes full from empty when the address bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= din;

  // Push at full with a pop reads the old word before it is overwritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      dout   <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      dout   <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ONE;
      if (pop) begin
        rd_ptr <= rd_ptr + ONE;
        dout   <= mem[rd_ptr[AW-1:0]];
      end
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end
endmodule

// File: rtl/fx3_stream_in_ctrl.sv
// FX3 stream-in producer: buffers the source stream and announces/drains it in FX3 bursts.
module fx3_stream_in_ctrl #(
  parameter int DATA_W      = fx3_pkg::DATA_W,
  parameter int BURST_WORDS = fx3_pkg::BURST_WORDS,
  parameter int FIFO_DEPTH  = fx3_pkg::FIFO_DEPTH,
  localparam int ADDR_W     = $clog2(FIFO_DEPTH)
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              fx3_resetn,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              fx3_read_ready,
  output logic [DATA_W-1:0] data,
  output logic              fx3_data_available,
  output logic              overflow,
  output logic              underflow,
  output logic [ADDR_W:0]   fill_level
);
  import fx3_pkg::*;

  localparam int CNT_W = (BURST_WORDS > 2) ? $clog2(BURST_WORDS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W:0]  THRESH   = (ADDR_W+1)'(BURST_WORDS);

  fx3_si_state_t  state;
  logic [CNT_W-1:0] burst_cnt;
  logic           full, empty, push, pop;
  logic [ADDR_W:0] fill_next;

  // The source cannot stall: a word at full survives only if a pop frees its slot.
  assign pop       = fx3_read_ready && !empty;
  assign push      = s_valid && (!full || pop);
  assign fill_next = fill_level + {{ADDR_W{1'b0}}, push} - {{ADDR_W{1'b0}}, pop};

  fx3_sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (aclk),
    .rst_n (aresetn),
    .clr   (!fx3_resetn),
    .push  (push),
    .pop   (pop),
    .din   (s_data),
    .dout  (data),
    .full  (full),
    .empty (empty),
    .count (fill_level)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state              <= IDLE;
      burst_cnt          <= '0;
      fx3_data_available <= 1'b0;
      overflow           <= 1'b0;
      underflow          <= 1'b0;
    end else if (!fx3_resetn) begin
      state              <= IDLE;
      burst_cnt          <= '0;
      fx3_data_available <= 1'b0;
      overflow           <= 1'b0;
      underflow          <= 1'b0;
    end else begin
      if (s_valid && full && !pop)   overflow  <= 1'b1;
      if (fx3_read_ready && empty)   underflow <= 1'b1;
      case (state)
        IDLE: if (fill_level >= THRESH) begin
          state              <= ARMED;
          fx3_data_available <= 1'b1;
        end
        // The pop that leaves ARMED is word 0 of the burst.
        ARMED: if (pop) begin
          state              <= BURST;
          fx3_data_available <= 1'b0;
          burst_cnt          <= CNT_ONE;
        end
        BURST: if (pop) begin
          if (burst_cnt == CNT_LAST) begin
            burst_cnt <= '0;
            if (fill_next >= THRESH) begin
              state              <= ARMED;
              fx3_data_available <= 1'b1;
            end else begin
              state              <= IDLE;
              fx3_data_available <= 1'b0;
            end
          end else begin
            burst_cnt <= burst_cnt + CNT_ONE;
          end
        end
        default: begin
          state              <= IDLE;
          fx3_data_available <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fx3_stream_in_ctrl.sv
// Directed bench for fx3_stream_in_ctrl at default parameters (BURST_WORDS=4092, depth 8192).
module tb_fx3_stream_in_ctrl;
  import fx3_pkg::*;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        fx3_resetn = 1'b1;
  logic        s_valid = 1'b0;
  logic        fx3_read_ready = 1'b0;
  fx3_word_t   s_data = '0;
  fx3_word_t   data;
  logic        fx3_data_available, overflow, underflow;
  logic [13:0] fill_level;

  int tests = 0;
  int fails = 0;

  always #5 aclk = ~aclk;

  fx3_stream_in_ctrl dut (
    .aclk               (aclk),
    .aresetn            (aresetn),
    .fx3_resetn         (fx3_resetn),
    .s_data             (s_data),
    .s_valid            (s_valid),
    .fx3_read_ready     (fx3_read_ready),
    .data               (data),
    .fx3_data_available (fx3_data_available),
    .overflow           (overflow),
    .underflow          (underflow),
    .fill_level         (fill_level)
  );

  task automatic step();
    @(posedge aclk); #1;
  endtask

  task automatic push_seq(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1; s_data = base + i; step();
    end
    s_valid = 1'b0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0; step(); step(); aresetn = 1'b1; step();
    fx3_read_ready = 1'b1; step(); fx3_read_ready = 1'b0;
    for (int i = 0; i < 100; i++) begin
      s_valid = 1'b1; s_data = 100 + i; fx3_read_ready = (i >= 50); step();
    end
    tests++; if (fill_level !== 14'd50) begin fails++; $display("FAIL pre_reset_fill got %0d want 50", fill_level); end
    tests++; if (data !== 32'd149) begin fails++; $display("FAIL pre_reset_data got %0d want 149", data); end
    tests++; if (underflow !== 1'b1) begin fails++; $display("FAIL pre_reset_underflow got %b want 1", underflow); end
    aresetn = 1'b0; #1;
    tests++; if (data !== 32'd0) begin fails++; $display("FAIL reset_data got %0h want 0", data); end
    tests++; if (fill_level !== 14'd0) begin fails++; $display("FAIL reset_fill got %0d want 0", fill_level); end
    tests++; if (overflow !== 1'b0 || underflow !== 1'b0) begin fails++; $display("FAIL reset_flags got ovf=%b unf=%b want 0 0", overflow, underflow); end
    tests++; if (fx3_data_available !== 1'b0) begin fails++; $display("FAIL reset_avail got %b want 0", fx3_data_available); end
    tests++; if (dut.state !== IDLE) begin fails++; $display("FAIL reset_state got %0d want IDLE", dut.state); end
    s_valid = 1'b0; fx3_read_ready = 1'b0; step(); aresetn = 1'b1; step();
  endtask

  task automatic test_threshold();
    push_seq(0, 4091); step(); step();
    tests++; if (fx3_data_available !== 1'b0 || fill_level !== 14'd4091) begin fails++; $display("FAIL thr_below got avail=%b fill=%0d want 0 4091", fx3_data_available, fill_level); end
    s_valid = 1'b1; s_data = 4091; step(); s_valid = 1'b0;
    tests++; if (fx3_data_available !== 1'b0) begin fails++; $display("FAIL thr_lag got %b want 0", fx3_data_available); end
    step();
    tests++; if (fx3_data_available !== 1'b1) begin fails++; $display("FAIL thr_avail got %b want 1", fx3_data_available); end
    tests++; if (overflow !== 1'b0 || fill_level !== 14'd4092) begin fails++; $display("FAIL thr_state got ovf=%b fill=%0d want 0 4092", overflow, fill_level); end
  endtask

  task automatic test_burst_drain();
    int errs = 0, av_bad = 0, fk = 0;
    fx3_word_t fg = '0;
    for (int k = 0; k < 4092; k++) begin
      fx3_read_ready = 1'b1; step();
      if (data !== k) begin if (errs == 0) begin fk = k; fg = data; end errs++; end
      if (fx3_data_available !== 1'b0) av_bad++;
    end
    fx3_read_ready = 1'b0;
    tests++; if (errs != 0) begin fails++; $display("FAIL drain_seq errs=%0d first k=%0d got %0d want %0d", errs, fk, fg, fk); end
    tests++; if (av_bad != 0) begin fails++; $display("FAIL drain_avail got %0d cycles high want 0", av_bad); end
    tests++; if (fill_level !== 14'd0 || dut.state !== IDLE) begin fails++; $display("FAIL drain_end got fill=%0d state=%0d want 0 IDLE", fill_level, dut.state); end
  endtask

  task automatic test_back_to_back();
    int errs = 0, fk = 0;
    fx3_word_t fg = '0;
    logic av_before = 1'b1, av_at = 1'b0;
    push_seq(10000, 8192);
    tests++; if (fill_level !== 14'd8192 || overflow !== 1'b0 || fx3_data_available !== 1'b1) begin fails++; $display("FAIL b2b_full got fill=%0d ovf=%b avail=%b want 8192 0 1", fill_level, overflow, fx3_data_available); end
    for (int k = 0; k < 8184; k++) begin
      fx3_read_ready = 1'b1; step();
      if (data !== 10000 + k) begin if (errs == 0) begin fk = k; fg = data; end errs++; end
      if (k == 4090) av_before = fx3_data_available;
      if (k == 4091) av_at = fx3_data_available;
    end
    fx3_read_ready = 1'b0;
    tests++; if (errs != 0) begin fails++; $display("FAIL b2b_seq errs=%0d first k=%0d got %0d want %0d", errs, fk, fg, 10000 + fk); end
    tests++; if (av_before !== 1'b0 || av_at !== 1'b1) begin fails++; $display("FAIL b2b_rearm got pop4091=%b pop4092=%b want 0 1", av_before, av_at); end
    tests++; if (fx3_data_available !== 1'b0 || fill_level !== 14'd8 || dut.state !== IDLE) begin fails++; $display("FAIL b2b_end got avail=%b fill=%0d state=%0d want 0 8 IDLE", fx3_data_available, fill_level, dut.state); end
    errs = 0;
    for (int k = 8184; k < 8192; k++) begin
      fx3_read_ready = 1'b1; step();
      if (data !== 10000 + k) errs++;
    end
    fx3_read_ready = 1'b0;
    tests++; if (errs != 0) begin fails++; $display("FAIL idle_pop_seq got %0d bad words want 0", errs); end
    tests++; if (fill_level !== 14'd0 || dut.state !== IDLE || dut.burst_cnt !== 12'd0) begin fails++; $display("FAIL idle_pop_state got fill=%0d state=%0d cnt=%0d want 0 IDLE 0", fill_level, dut.state, dut.burst_cnt); end
  endtask

  task automatic test_overflow();
    push_seq(20000, 8192);
    tests++; if (fill_level !== 14'd8192 || overflow !== 1'b0) begin fails++; $display("FAIL ovf_fill got fill=%0d ovf=%b want 8192 0", fill_level, overflow); end
    s_valid = 1'b1; s_data = 32'hDEAD_0001; step(); s_valid = 1'b0;
    tests++; if (overflow !== 1'b1 || fill_level !== 14'd8192) begin fails++; $display("FAIL ovf_drop got ovf=%b fill=%0d want 1 8192", overflow, fill_level); end
    step();
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky got %b want 1", overflow); end
    s_valid = 1'b1; s_data = 32'hBEEF_0002; fx3_read_ready = 1'b1; step();
    s_valid = 1'b0; fx3_read_ready = 1'b0;
    tests++; if (fill_level !== 14'd8192 || data !== 32'd20000) begin fails++; $display("FAIL ovf_pushpop got fill=%0d data=%0d want 8192 20000", fill_level, data); end
  endtask

  // Continues the burst opened by the push+pop at full; words expected are 20001.. then BEEF0002.
  task automatic test_pause_underflow();
    int errs = 0, hold_bad = 0, idx = 1, fk = 0;
    fx3_word_t want, fg = '0;
    for (int k = 0; k < 1000; k++) begin
      fx3_read_ready = 1'b1; step();
      want = 20000 + idx;
      if (data !== want) begin if (errs == 0) begin fk = idx; fg = data; end errs++; end
      idx++;
    end
    fx3_read_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (data !== 32'd21000 || fill_level !== 14'd7192) hold_bad++;
    end
    tests++; if (hold_bad != 0 || dut.state !== BURST || fx3_data_available !== 1'b0) begin fails++; $display("FAIL pause_hold got bad=%0d state=%0d avail=%b want 0 BURST 0", hold_bad, dut.state, fx3_data_available); end
    for (int k = 0; k < 3091; k++) begin
      fx3_read_ready = 1'b1; step();
      want = 20000 + idx;
      if (data !== want) begin if (errs == 0) begin fk = idx; fg = data; end errs++; end
      idx++;
    end
    tests++; if (fx3_data_available !== 1'b1 || fill_level !== 14'd4101) begin fails++; $display("FAIL pause_burst_end got avail=%b fill=%0d want 1 4101", fx3_data_available, fill_level); end
    for (int k = 0; k < 4101; k++) begin
      fx3_read_ready = 1'b1; step();
      want = (idx < 8192) ? 20000 + idx : 32'hBEEF_0002;
      if (data !== want) begin if (errs == 0) begin fk = idx; fg = data; end errs++; end
      idx++;
    end
    tests++; if (errs != 0) begin fails++; $display("FAIL pause_seq errs=%0d first idx=%0d got %0h", errs, fk, fg); end
    tests++; if (fill_level !== 14'd0 || fx3_data_available !== 1'b0 || underflow !== 1'b0) begin fails++; $display("FAIL pause_empty got fill=%0d avail=%b unf=%b want 0 0 0", fill_level, fx3_data_available, underflow); end
    step(); fx3_read_ready = 1'b0;
    tests++; if (underflow !== 1'b1 || data !== 32'hBEEF_0002) begin fails++; $display("FAIL underflow got unf=%b data=%0h want 1 beef0002", underflow, data); end
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_kept got %b want 1", overflow); end
    fx3_resetn = 1'b0; step(); fx3_resetn = 1'b1;
    tests++; if (overflow !== 1'b0 || underflow !== 1'b0) begin fails++; $display("FAIL soft_reset_flags got ovf=%b unf=%b want 0 0", overflow, underflow); end
    tests++; if (data !== 32'd0 || fill_level !== 14'd0 || fx3_data_available !== 1'b0) begin fails++; $display("FAIL soft_reset_out got data=%0h fill=%0d avail=%b want 0 0 0", data, fill_level, fx3_data_available); end
  endtask

  initial begin
    test_reset();
    test_threshold();
    test_burst_drain();
    test_back_to_back();
    test_overflow();
    test_pause_underflow();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
